// File: rtl/display_scan_driver.sv
// display_scan_driver
//
// Drives a four-digit, common-anode 7-segment display. The scan timer
// supplies a slowly toggling scan signal. Every toggle, rising or falling,
// moves the display on to the next digit. Each digit change starts a short
// blank interval with all anodes off, so the previous digit's segments do not
// ghost onto the new anode. The 16-bit value is latched only at frame start,
// so a frame never shows a mix of old and new nibbles.
//
// Parameters
//   BLANK_CYCLES : clk cycles with all anodes off after each digit change
//                  (0..1023). A value of 0 still gives one blank cycle.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   scan_in    in   toggling scan signal (untrusted, synchronized here)
//   value      in   four hex nibbles; nibble i is shown on digit i (0 = rightmost)
//   dp_mask    in   bit i lights the decimal point of digit i (sampled live)
//   blank_lz   in   1 = suppress leading zeros (sampled live)
//   an         out  anodes, active-low, one-hot-low while a digit is shown
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   frame_done out  one-cycle pulse when the digit index wraps from 3 to 0

module display_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_in,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [9:0] BLANK_LOAD = 10'(BLANK_CYCLES);

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic        edge_q, edge_d;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic [15:0] shifted;
  logic [3:0]  nibble;
  logic        suppress;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer plus a history flop. The toggle detect is
  // registered once more, so a toggle acts on state three clocks after it
  // is first sampled.
  always_comb begin
    s1_d   = scan_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    edge_d = s2_q ^ s3_q;
  end

  // Digit sequencing. Any toggle, even one in the middle of a blank, moves
  // to the next digit and restarts the blank count. The shadow copy of the
  // value is refreshed only when a new frame starts.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_q) begin
          idx_d        = 2'd0;
          shadow_d     = value;
          frame_done_d = 1'b1;
          cnt_d        = BLANK_LOAD;
          state_d      = ST_BLANK;
        end
      end
      ST_BLANK, ST_SHOW: begin
        if (edge_q) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = BLANK_LOAD;
          state_d = ST_BLANK;
          if (idx_q == 2'd3) begin
            shadow_d     = value;
            frame_done_d = 1'b1;
          end
        end else if (state_q == ST_BLANK) begin
          if (cnt_q == 10'd0) begin
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode is computed from the next state so that the registered
  // outputs change on the same edge as the state. A digit is a leading zero
  // when it and every digit to its left are zero. Digit 0 is never blanked,
  // so a value of zero still shows "0".
  always_comb begin
    shifted  = shadow_d >> {idx_d, 2'b00};
    nibble   = shifted[3:0];
    suppress = blank_lz && (idx_d != 2'd0) && (shifted == 16'd0);
    an_d     = 4'b1111;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    if ((state_d == ST_SHOW) && !suppress) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = hex_to_seg(nibble);
      dp_d  = ~dp_mask[idx_d];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      edge_q       <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 10'd0;
      shadow_q     <= 16'd0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      edge_q       <= edge_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
//
// Directed bench for display_scan_driver with BLANK_CYCLES = 4. Inputs are
// driven and outputs sampled on the falling clock edge. A toggle driven at a
// falling edge takes effect on the state three rising edges after the next
// one (E3). The digit then lights at E3 + 5. After m falling edges, the
// outputs reflect rising edge E(m-1).

module tb_display_scan_driver;

  logic        clk;
  logic        rst;
  logic        scanIn;
  logic [15:0] value;
  logic [3:0]  dpMask;
  logic        blankLz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frameDone;

  int compareCount  = 0;
  int mismatchCount = 0;
  int fdCount       = 0;
  int fdBase;
  int c;
  logic idleBad;
  logic rapidBad;

  display_scan_driver #(.BLANK_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_in    (scanIn),
    .value      (value),
    .dp_mask    (dpMask),
    .blank_lz   (blankLz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frameDone)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (frameDone === 1'b1) fdCount++;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Toggle the scan signal, then wait the given number of falling edges.
  task automatic applyStimulus(input int gapCycles);
    scanIn = ~scanIn;
    waitCycles(gapCycles);
  endtask

  // Check the anode, segment and decimal-point outputs together.
  task automatic checkDigit(input string tag, input logic [3:0] expAn,
                            input logic [6:0] expSeg, input logic expDp);
    checkOutput({tag, "_an"}, 32'(an), 32'(expAn));
    checkOutput({tag, "_seg"}, 32'(seg), 32'(expSeg));
    checkOutput({tag, "_dp"}, 32'(dp), 32'(expDp));
  endtask

  initial begin
    // Reset, then stay idle.
    rst     = 1'b1;
    scanIn  = 1'b0;
    value   = 16'h0000;
    dpMask  = 4'b0000;
    blankLz = 1'b0;
    waitCycles(2);
    checkDigit("reset", 4'b1111, 7'b1111111, 1'b1);
    checkOutput("reset_frame_done", 32'(frameDone), 32'd0);
    rst = 1'b0;
    idleBad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) idleBad = 1'b1;
    end
    checkOutput("idle_outputs_off", 32'(idleBad), 32'd0);
    checkOutput("idle_frame_done_count", 32'(fdCount), 32'd0);

    // First toggle: blank from E3, digit 0 ("4") lights at E8.
    value  = 16'h1234;
    fdBase = fdCount;
    applyStimulus(4);
    checkOutput("lat_e3_an", 32'(an), 32'hF);
    checkOutput("lat_e3_frame_done", 32'(frameDone), 32'd1);
    waitCycles(4);
    checkOutput("lat_e7_an", 32'(an), 32'hF);
    waitCycles(1);
    checkDigit("lat_e8", 4'b1110, 7'b0011001, 1'b1);
    waitCycles(11);
    checkOutput("lat_frame_done_count", 32'(fdCount - fdBase), 32'd1);

    // Rotation. The new value must not tear the current frame.
    applyStimulus(20);
    checkDigit("rot_d1", 4'b1101, 7'b0110000, 1'b1);
    value = 16'hABCD;
    applyStimulus(20);
    checkDigit("rot_d2", 4'b1011, 7'b0100100, 1'b1);
    applyStimulus(20);
    checkDigit("rot_d3", 4'b0111, 7'b1111001, 1'b1);
    fdBase = fdCount;
    applyStimulus(4);
    checkOutput("wrap_frame_done_hi", 32'(frameDone), 32'd1);
    waitCycles(1);
    checkOutput("wrap_frame_done_lo", 32'(frameDone), 32'd0);
    waitCycles(15);
    checkDigit("wrap_d0", 4'b1110, 7'b0100001, 1'b1);
    checkOutput("wrap_frame_done_count", 32'(fdCount - fdBase), 32'd1);

    // Leading zeros. 0050 is captured at the next wrap; until then the
    // ABCD frame finishes with all decimal points lit.
    value   = 16'h0050;
    blankLz = 1'b1;
    dpMask  = 4'b1111;
    applyStimulus(20);
    applyStimulus(20);
    applyStimulus(20);
    checkDigit("lz_old_d3", 4'b0111, 7'b0001000, 1'b0);
    applyStimulus(20);
    checkDigit("lz_d0", 4'b1110, 7'b1000000, 1'b0);
    applyStimulus(20);
    checkDigit("lz_d1", 4'b1101, 7'b0010010, 1'b0);
    applyStimulus(20);
    checkDigit("lz_d2_blank", 4'b1111, 7'b1111111, 1'b1);
    applyStimulus(20);
    checkDigit("lz_d3_blank", 4'b1111, 7'b1111111, 1'b1);
    blankLz = 1'b0;
    waitCycles(2);
    checkDigit("nolz_d3", 4'b0111, 7'b1000000, 1'b0);
    applyStimulus(20);
    applyStimulus(20);
    applyStimulus(20);
    checkDigit("nolz_d2", 4'b1011, 7'b1000000, 1'b0);

    // Rapid toggles two cycles apart, starting from digit 2. The anodes
    // stay off until five cycles after the last edge takes effect. Digit
    // 2 is reached again with two wraps on the way.
    fdBase   = fdCount;
    rapidBad = 1'b0;
    c        = 0;
    for (int k = 0; k < 8; k++) begin
      scanIn = ~scanIn;
      repeat (2) begin
        @(negedge clk);
        c++;
        if (c >= 4 && an !== 4'b1111) rapidBad = 1'b1;
      end
    end
    repeat (6) begin
      @(negedge clk);
      c++;
      if (an !== 4'b1111) rapidBad = 1'b1;
    end
    checkOutput("rapid_anodes_off", 32'(rapidBad), 32'd0);
    @(negedge clk);
    checkDigit("rapid_final_d2", 4'b1011, 7'b1000000, 1'b0);
    checkOutput("rapid_frame_done_count", 32'(fdCount - fdBase), 32'd2);

    // Reset while digit 2 is shown. The scan line is returned low while
    // reset is held, so releasing reset does not create a toggle.
    value = 16'h9876;
    waitCycles(3);
    rst = 1'b1;
    waitCycles(1);
    checkDigit("rst_mid", 4'b1111, 7'b1111111, 1'b1);
    scanIn = 1'b0;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(10);
    checkDigit("post_rst_idle", 4'b1111, 7'b1111111, 1'b1);
    fdBase = fdCount;
    applyStimulus(4);
    checkOutput("post_rst_frame_done", 32'(frameDone), 32'd1);
    waitCycles(5);
    checkDigit("post_rst_d0", 4'b1110, 7'b0000010, 1'b0);
    waitCycles(2);
    checkOutput("post_rst_frame_done_count", 32'(fdCount - fdBase), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Consumer end of the display multiplexing timer: takes the slow toggling scan signal produced by the scan timer, synchronizes it, and on every toggle advances through the four 7-segment digits of the board display. It drives active-low anodes, segments and decimal point with hex decoding, a per-digit anti-ghosting blank interval and optional leading-zero suppression. It sits between the Gray-decoder datapath (which supplies the 16-bit value) and the board pins.

## Interface
- BLANK_CYCLES, default 100: clk cycles with all anodes off after each digit change; legal range 0..1023.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- scan_in  in  1  toggling scan signal from the scan timer; asynchronous to nothing but treated as untrusted, so it is synchronized.
- value  in  16  four hex nibbles; nibble i = value[4i+3:4i] shows on digit i, where digit 0 is rightmost.
- dp_mask  in  4  bit i = 1 lights the decimal point of digit i.
- blank_lz  in  1  1 = suppress leading zeros.
- an  out  4  anodes, active-low, one-hot-low when showing.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the digit index wraps 3 -> 0.

## Operation
- Synchronizer: scan_in passes through 2 flops (s1, s2), then a history flop s3. edge = s2 ^ s3. Both rising and falling toggles count.
- State machine: IDLE, BLANK, SHOW.
  - IDLE (after reset): outputs off. On edge: idx <= 0, shadow <= value, frame_done pulses, go to BLANK.
  - BLANK: outputs off, down-counter cnt runs. When cnt == 0, go to SHOW.
  - SHOW: drive digit idx from the shadow register.
  - On edge in BLANK or SHOW: idx <= idx + 1 mod 4, cnt <= BLANK_CYCLES, go to BLANK. On the 3 -> 0 wrap, also shadow <= value and pulse frame_done.
  - An edge during BLANK restarts the count; it does not extend the current digit.
- BLANK_CYCLES = 0: BLANK lasts exactly one cycle.
- Shadow register: value is only captured at frame start, so a frame never shows a mix of old and new nibbles. dp_mask and blank_lz are sampled live.
- Decode of hex to active-low segments:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Leading-zero suppression: when blank_lz = 1, digit i (i >= 1) is suppressed if shadow nibbles i..3 are all zero. Digit 0 is never suppressed.
- A suppressed digit in SHOW gives an = 1111, seg = 1111111 and dp = 1, regardless of dp_mask.
- Outputs off means an = 1111, seg = 1111111, dp = 1.
- SHOW output for a non-suppressed digit:
  - an = ~(4'b0001 << idx).
  - seg = decode(shadow nibble idx).
  - dp = ~dp_mask[idx].

## Timing
- All outputs are registered.
- Reset values (rst high on a clk edge):
  - an = 1111, seg = 1111111, dp = 1, frame_done = 0.
  - idx = 0, cnt = 0, shadow = 0, s1/s2/s3 = 0, state = IDLE.
- rst has priority over edge in the same cycle. rst mid-frame returns to IDLE with outputs off on the next edge.
- Edge latency: scan_in toggles before clk edge E0. s1 updates at E0, s2 at E1, the edge is seen at E2, and state/outputs update at E3 (an = 1111 from E3).
- Digit visible: an goes low at E3 + BLANK_CYCLES + 1.
- frame_done is high for exactly the cycle after the wrap edge (E3 to E4).
- scan_in toggles faster than 3 + BLANK_CYCLES cycles apart are still each counted; the digit may then never reach SHOW. This is legal.
- With the scan timer at 100 MHz, toggles arrive every 1 ms: 4 ms frame, 250 Hz refresh.

## Test plan
- Reset and idle (BLANK_CYCLES = 4): hold rst 2 cycles, scan_in static for 100 cycles -> an = 1111, seg = 1111111, dp = 1, frame_done never asserted.
- First scan and latency: value = 16'h1234, toggle scan_in once -> an = 1111 at E3, then an = 1110 and seg = 0011001 ("4") exactly 5 cycles later; frame_done pulses once.
- Full rotation and tearing:
  - 4 toggles spaced 20 cycles apart -> an sequence 1110, 1101, 1011, 0111 showing 4, 3, 2, 1.
  - Change value to 16'hABCD after the 2nd toggle -> 2 and 1 are still shown.
  - 5th toggle -> D (0100001) on an = 1110, with frame_done pulsing.
- Leading zeros: value = 16'h0050, blank_lz = 1, dp_mask = 1111, 4 toggles -> digits 0 and 1 show 0 and 5 with dp = 0; digits 2 and 3 give an = 1111 and dp = 1. With blank_lz = 0, digits 2 and 3 show 1000000.
- Rapid toggles: toggles 2 cycles apart -> idx advances on each, an stays 1111 throughout, frame_done pulses on every 4th toggle.
- Reset mid-SHOW: assert rst while digit 2 is shown -> all outputs off next cycle; the next toggle restarts at digit 0 with a freshly captured value.
